// File: rtl/cmos_cfg_pkg.sv
// Shared constants for the camera window/timing register sequencer.
package cmos_cfg_pkg;

  localparam int I2C_W = 24;

  // Output-window and frame-timing register addresses
  localparam logic [15:0] REG_DVPHO_H = 16'h3808;
  localparam logic [15:0] REG_DVPHO_L = 16'h3809;
  localparam logic [15:0] REG_DVPVO_H = 16'h380A;
  localparam logic [15:0] REG_DVPVO_L = 16'h380B;
  localparam logic [15:0] REG_HTS_H   = 16'h380C;
  localparam logic [15:0] REG_HTS_L   = 16'h380D;
  localparam logic [15:0] REG_VTS_H   = 16'h380E;
  localparam logic [15:0] REG_VTS_L   = 16'h380F;

  localparam logic [2:0] ST_INIT  = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_WAIT  = 3'd4;
  localparam logic [2:0] ST_NEXT  = 3'd5;

  typedef enum logic [2:0] {
    S_INIT  = ST_INIT,
    S_IDLE  = ST_IDLE,
    S_LOAD  = ST_LOAD,
    S_WRITE = ST_WRITE,
    S_WAIT  = ST_WAIT,
    S_NEXT  = ST_NEXT
  } state_e;

  // Upper five bits of a 13-bit size, zero-extended to a register byte
  function automatic logic [7:0] hi5(input logic [12:0] v);
    return {3'b000, v[12:8]};
  endfunction

endpackage

// File: rtl/cmos_size_reg_lut.sv
// Maps a write index plus the shadowed geometry to one {addr, data} word.
module cmos_size_reg_lut
  import cmos_cfg_pkg::*;
(
  input  logic [2:0]       idx_i,
  input  logic [12:0]      h_i,
  input  logic [12:0]      v_i,
  input  logic [12:0]      hts_i,
  input  logic [12:0]      vts_i,
  output logic [I2C_W-1:0] word_o
);

  // Register order: window width, window height, HTS, VTS (high byte first)
  always_comb begin
    word_o = '0;
    case (idx_i)
      3'd0: word_o = {REG_DVPHO_H, hi5(h_i)};
      3'd1: word_o = {REG_DVPHO_L, h_i[7:0]};
      3'd2: word_o = {REG_DVPVO_H, hi5(v_i)};
      3'd3: word_o = {REG_DVPVO_L, v_i[7:0]};
      3'd4: word_o = {REG_HTS_H,   hi5(hts_i)};
      3'd5: word_o = {REG_HTS_L,   hts_i[7:0]};
      3'd6: word_o = {REG_VTS_H,   hi5(vts_i)};
      3'd7: word_o = {REG_VTS_L,   vts_i[7:0]};
      default: word_o = '0;
    endcase
  end

endmodule

// File: rtl/cmos_size_cfg.sv
// Programs DVPHO/DVPVO/HTS/VTS over the I2C write driver, retrying NACKs and
// re-running whenever the requested geometry changes.
module cmos_size_cfg
  import cmos_cfg_pkg::*;
#(
  parameter logic [19:0] INIT_DLY  = 20'd1000,
  parameter logic [1:0]  MAX_RETRY = 2'd3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic [12:0]      cmos_h_pixel,
  input  logic [12:0]      cmos_v_pixel,
  input  logic [12:0]      total_h_pixel,
  input  logic [12:0]      total_v_pixel,
  output logic             i2c_exec,
  output logic [I2C_W-1:0] i2c_data,
  input  logic             i2c_done,
  input  logic             i2c_ack,
  output logic             cfg_busy,
  output logic             cfg_done,
  output logic             cfg_err
);

  state_e           state_q, state_d;
  logic [19:0]      cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [1:0]       retry_q, retry_d;
  logic [12:0]      h_q, h_d, v_q, v_d, hts_q, hts_d, vts_q, vts_d;
  logic             pend_q, pend_d;
  logic             exec_q, exec_d;
  logic [I2C_W-1:0] data_q, data_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [I2C_W-1:0] lut_word;
  logic             size_diff;

  cmos_size_reg_lut u_lut (
    .idx_i  (idx_q),
    .h_i    (h_q),
    .v_i    (v_q),
    .hts_i  (hts_q),
    .vts_i  (vts_q),
    .word_o (lut_word)
  );

  assign size_diff = (cmos_h_pixel  != h_q)   || (cmos_v_pixel  != v_q) ||
                     (total_h_pixel != hts_q) || (total_v_pixel != vts_q);

  // Next-state and register updates for the write sequencer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    retry_d = retry_q;
    h_d     = h_q;
    v_d     = v_q;
    hts_d   = hts_q;
    vts_d   = vts_q;
    pend_d  = pend_q;
    exec_d  = 1'b0;
    data_d  = data_q;
    done_d  = done_q;
    err_d   = err_q;

    // A request arriving mid-sequence is remembered and replayed afterwards
    if ((state_q == S_WRITE || state_q == S_WAIT || state_q == S_NEXT) &&
        (cfg_start || size_diff))
      pend_d = 1'b1;

    case (state_q)
      S_INIT: begin
        if (cnt_q == INIT_DLY - 20'd1) begin
          cnt_d   = '0;
          state_d = S_LOAD;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      S_IDLE: begin
        if (cfg_start || pend_q || size_diff) state_d = S_LOAD;
      end
      S_LOAD: begin
        h_d     = cmos_h_pixel;
        v_d     = cmos_v_pixel;
        hts_d   = total_h_pixel;
        vts_d   = total_v_pixel;
        idx_d   = '0;
        retry_d = '0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        pend_d  = 1'b0;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        data_d  = lut_word;
        exec_d  = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i2c_done) begin
          if (!i2c_ack) begin
            // Flag completion on the way into NEXT so it lands one cycle after done
            if (idx_q == 3'd7) done_d = 1'b1;
            state_d = S_NEXT;
          end else if (retry_q < MAX_RETRY) begin
            retry_d = retry_q + 2'd1;
            state_d = S_WRITE;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_NEXT: begin
        if (idx_q != 3'd7) begin
          idx_d   = idx_q + 3'd1;
          retry_d = '0;
          state_d = S_WRITE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      idx_q   <= '0;
      retry_q <= '0;
      h_q     <= '0;
      v_q     <= '0;
      hts_q   <= '0;
      vts_q   <= '0;
      pend_q  <= 1'b0;
      exec_q  <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      h_q     <= h_d;
      v_q     <= v_d;
      hts_q   <= hts_d;
      vts_q   <= vts_d;
      pend_q  <= pend_d;
      exec_q  <= exec_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Busy ends with the final WAIT, so it is already low in the closing NEXT
  assign cfg_busy = (state_q == S_LOAD) || (state_q == S_WRITE) ||
                    (state_q == S_WAIT) || (state_q == S_NEXT && idx_q != 3'd7);
  assign i2c_exec = exec_q;
  assign i2c_data = data_q;
  assign cfg_done = done_q;
  assign cfg_err  = err_q;

endmodule

// File: tb/tb_cmos_size_cfg.sv
// Randomized self-checking bench for cmos_size_cfg with an I2C driver model.
module tb_cmos_size_cfg;

  localparam logic [19:0] DLY = 20'd20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_start;
  logic [12:0] cmos_h_pixel, cmos_v_pixel, total_h_pixel, total_v_pixel;
  logic        i2c_exec;
  logic [23:0] i2c_data;
  logic        i2c_done, i2c_ack;
  logic        cfg_busy, cfg_done, cfg_err;

  int checks = 0;
  int failures = 0;

  logic [23:0] log_q[$];
  logic [23:0] exp_q[$];
  int lat_min = 0, lat_max = 2;
  int nack_addr = 0, nack_cnt = 0;

  cmos_size_cfg #(.INIT_DLY(DLY), .MAX_RETRY(2'd3)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_start     (cfg_start),
    .cmos_h_pixel  (cmos_h_pixel),
    .cmos_v_pixel  (cmos_v_pixel),
    .total_h_pixel (total_h_pixel),
    .total_v_pixel (total_v_pixel),
    .i2c_exec      (i2c_exec),
    .i2c_data      (i2c_data),
    .i2c_done      (i2c_done),
    .i2c_ack       (i2c_ack),
    .cfg_busy      (cfg_busy),
    .cfg_done      (cfg_done),
    .cfg_err       (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: the eight writes a geometry should produce, in order, with
  // nn extra copies of write nidx for NACK retries
  task automatic add_exp(input int h, input int v, input int ht, input int vt,
                         input int nidx, input int nn);
    int d[8];
    d[0] = h / 256;  d[1] = h % 256;
    d[2] = v / 256;  d[3] = v % 256;
    d[4] = ht / 256; d[5] = ht % 256;
    d[6] = vt / 256; d[7] = vt % 256;
    for (int i = 0; i < 8; i++)
      for (int r = 0; r <= ((i == nidx) ? nn : 0); r++)
        exp_q.push_back(24'((32'h3808 + i) * 256 + d[i]));
  endtask

  task automatic cmp_log(input string tag);
    chk($sformatf("%s_cnt", tag), log_q.size(), exp_q.size());
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), log_q[i], exp_q[i]);
  endtask

  task automatic wait_quiet(input string tag);
    int low = 0;
    for (int c = 0; c < 3000 && low < 8; c++) begin
      @(posedge clk); #1;
      low = cfg_busy ? 0 : low + 1;
    end
    chk($sformatf("%s_quiet", tag), low, 8);
  endtask

  task automatic wait_log(input int n);
    for (int c = 0; c < 2000 && log_q.size() < n; c++) begin
      @(posedge clk); #1;
    end
    chk("wait_log", 32'(log_q.size() >= n), 1);
  endtask

  task automatic set_geom(input int h, input int v, input int ht, input int vt, input bit start);
    @(negedge clk);
    cmos_h_pixel = 13'(h); cmos_v_pixel = 13'(v);
    total_h_pixel = 13'(ht); total_v_pixel = 13'(vt);
    cfg_start = start;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic first_exec(input string tag);
    int n = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      n++;
      if (i2c_exec) break;
    end
    chk(tag, n, 32'(DLY) + 2);
  endtask

  // Driver model: logs each write, answers after a random latency
  initial begin
    logic ack;
    int lat;
    i2c_done = 1'b0;
    i2c_ack  = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (i2c_exec === 1'b1) begin
        log_q.push_back(i2c_data);
        ack = (nack_cnt > 0) && (int'(i2c_data[23:8]) == nack_addr);
        if (ack) nack_cnt--;
        lat = $urandom_range(lat_max, lat_min);
        for (int k = 0; k < lat; k++) begin
          @(posedge clk); #1;
        end
        i2c_done = 1'b1;
        i2c_ack  = ack;
        @(posedge clk); #1;
        i2c_done = 1'b0;
        i2c_ack  = 1'b0;
      end
    end
  end

  initial begin
    int h, v, ht, vt, ni, nn;
    rst_n = 1'b0;
    cfg_start = 1'b0;
    cmos_h_pixel = 13'd800;  cmos_v_pixel = 13'd480;
    total_h_pixel = 13'd1800; total_v_pixel = 13'd1000;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_exec", i2c_exec, 0);
    chk("rst_data", i2c_data, 0);
    chk("rst_busy", cfg_busy, 0);
    chk("rst_done", cfg_done, 0);
    chk("rst_err",  cfg_err,  0);

    // Power-up sequence
    @(negedge clk);
    rst_n = 1'b1;
    first_exec("first_exec_lat");
    wait_quiet("boot");
    exp_q.delete();
    add_exp(800, 480, 1800, 1000, -1, 0);
    cmp_log("boot");
    chk("boot_w1_const", (log_q.size() > 1) ? log_q[1] : 24'h0, 24'h380920);
    chk("boot_w7_const", (log_q.size() > 7) ? log_q[7] : 24'h0, 24'h380FE8);
    chk("boot_done", cfg_done, 1);
    chk("boot_err",  cfg_err,  0);

    // Live change in IDLE re-runs automatically
    log_q.delete();
    set_geom(1280, 800, 2570, 980, 0);
    wait_quiet("chg");
    exp_q.delete();
    add_exp(1280, 800, 2570, 980, -1, 0);
    cmp_log("chg");
    chk("chg_done", cfg_done, 1);

    // Stray done outside WAIT does nothing
    log_q.delete();
    @(negedge clk); i2c_done = 1'b1; i2c_ack = 1'b1;
    @(negedge clk); i2c_done = 1'b0; i2c_ack = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("stray_busy", cfg_busy, 0);
    chk("stray_done", cfg_done, 1);
    chk("stray_err",  cfg_err,  0);
    chk("stray_log",  log_q.size(), 0);

    // Two NACKs on index 3, then OK
    nack_addr = 32'h380B; nack_cnt = 2;
    set_geom(1280, 800, 2570, 980, 1);
    wait_quiet("retry");
    exp_q.delete();
    add_exp(1280, 800, 2570, 980, 3, 2);
    cmp_log("retry");
    chk("retry_done", cfg_done, 1);
    chk("retry_err",  cfg_err,  0);

    // Four NACKs on index 0 abort the sequence
    log_q.delete();
    nack_addr = 32'h3808; nack_cnt = 4;
    set_geom(1280, 800, 2570, 980, 1);
    wait_quiet("abort");
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(24'h380805);
    cmp_log("abort");
    chk("abort_err",  cfg_err,  1);
    chk("abort_done", cfg_done, 0);
    chk("abort_busy", cfg_busy, 0);
    nack_cnt = 0;

    // Change during index-4 WAIT: old run completes, then rerun with new values
    log_q.delete();
    lat_min = 2; lat_max = 3;
    set_geom(800, 480, 1800, 1000, 0);
    wait_log(5);
    set_geom(1024, 600, 1800, 1000, 0);
    wait_quiet("pend");
    exp_q.delete();
    add_exp(800, 480, 1800, 1000, -1, 0);
    add_exp(1024, 600, 1800, 1000, -1, 0);
    cmp_log("pend");
    chk("pend_w8_const", (log_q.size() > 8) ? log_q[8] : 24'h0, 24'h380804);
    chk("pend_done", cfg_done, 1);
    lat_min = 0;

    // Randomized geometries, latencies and recoverable NACKs
    for (int it = 0; it < 8; it++) begin
      h  = $urandom_range(8191, 0); v  = $urandom_range(8191, 0);
      ht = $urandom_range(8191, 0); vt = $urandom_range(8191, 0);
      ni = $urandom_range(7, 0);    nn = $urandom_range(2, 0);
      lat_max = $urandom_range(3, 0);
      nack_addr = 32'h3808 + ni; nack_cnt = nn;
      log_q.delete();
      set_geom(h, v, ht, vt, 1);
      wait_quiet($sformatf("rnd%0d", it));
      exp_q.delete();
      add_exp(h, v, ht, vt, ni, nn);
      cmp_log($sformatf("rnd%0d", it));
      chk($sformatf("rnd%0d_done", it), cfg_done, 1);
      chk($sformatf("rnd%0d_err", it),  cfg_err,  0);
    end
    nack_cnt = 0;

    // Reset during index-5 WAIT
    lat_min = 3; lat_max = 3;
    log_q.delete();
    set_geom(640, 480, 800, 525, 1);
    wait_log(6);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_exec", i2c_exec, 0);
    chk("mid_rst_busy", cfg_busy, 0);
    chk("mid_rst_done", cfg_done, 0);
    repeat (6) @(posedge clk);
    log_q.delete();
    lat_min = 0; lat_max = 2;
    @(negedge clk);
    rst_n = 1'b1;
    first_exec("rerst_exec_lat");
    wait_quiet("rerst");
    exp_q.delete();
    add_exp(640, 480, 800, 525, -1, 0);
    cmp_log("rerst");
    chk("rerst_done", cfg_done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
